// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C register-access master and its
// quarter-period tick divider.
package i2c_master_pkg;

   localparam int unsigned CLK_DIV_DFLT = 125;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_SEND_BYTE,
      ST_GET_ACK,
      ST_RESTART,
      ST_READ_BYTE,
      ST_SEND_NACK,
      ST_STOP,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      STS_IDLE = 2'b00,
      STS_BUSY = 2'b01,
      STS_DONE = 2'b10,
      STS_NACK = 2'b11
   } sts_e;

   // Quarter index at the moment a tick arrives: the tick moves the bit into
   // the next quarter (mid-low SDA change, SCL rise, mid-high sample, bit end).
   localparam logic [1:0] PH_CHG  = 2'd0;
   localparam logic [1:0] PH_RISE = 2'd1;
   localparam logic [1:0] PH_SMP  = 2'd2;
   localparam logic [1:0] PH_END  = 2'd3;

   typedef struct packed {
      logic       rw;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
   } req_t;

endpackage

// File: rtl/i2c_clk_tick.sv
// Free-running divider: one-cycle tick every DIV clocks while enabled,
// held at zero otherwise so every transaction starts on a fresh quarter.
module i2c_clk_tick #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (!en_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master.sv
// I2C register-access master: one register write or read per start pulse,
// framed START / address / register / [RESTART / address] / data / STOP.
module i2c_master
   import i2c_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DFLT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       rw_i,
   input  logic [6:0] dev_addr_i,
   input  logic [7:0] reg_addr_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] rd_data_o,
   output logic [1:0] sts_o,
   output logic       sts_wr_o,
   output logic       scl_o,
   output logic       sda_oe_o,
   input  logic       sda_in_i
);

   state_e     state_q, state_d;
   req_t       req_q, req_d;
   logic [1:0] ph_q, ph_d;
   logic [2:0] bit_q, bit_d;
   logic [1:0] step_q, step_d;
   logic [7:0] shreg_q, shreg_d;
   logic       err_q, err_d;
   logic       scl_q, scl_d;
   logic       sda_oe_q, sda_oe_d;
   sts_e       sts_q, sts_d;
   logic       sts_wr_q, sts_wr_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       tick, q_chg, q_rise, q_smp, q_end;

   i2c_clk_tick #(.DIV(CLK_DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_q != ST_IDLE),
      .tick_o (tick)
   );

   assign q_chg  = tick && (ph_q == PH_CHG);
   assign q_rise = tick && (ph_q == PH_RISE);
   assign q_smp  = tick && (ph_q == PH_SMP);
   assign q_end  = tick && (ph_q == PH_END);

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      ph_d      = tick ? ph_q + 2'd1 : ph_q;
      bit_d     = bit_q;
      step_d    = step_q;
      shreg_d   = shreg_q;
      err_d     = err_q;
      scl_d     = scl_q;
      sda_oe_d  = sda_oe_q;
      sts_d     = sts_q;
      sts_wr_d  = 1'b0;
      rd_data_d = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            ph_d     = 2'd0;
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
            if (start_i) begin
               req_d    = '{rw: rw_i, dev: dev_addr_i, rg: reg_addr_i, wd: wr_data_i};
               shreg_d  = {dev_addr_i, 1'b0};
               bit_d    = 3'd0;
               step_d   = 2'd0;
               err_d    = 1'b0;
               sts_d    = STS_BUSY;
               sts_wr_d = 1'b1;
               state_d  = ST_START;
            end
         end
         // SCL stays high for the whole slot; SDA falls a quarter in.
         ST_START: begin
            if (q_chg) sda_oe_d = 1'b1;
            if (q_end) begin
               scl_d   = 1'b0;
               state_d = ST_SEND_BYTE;
            end
         end
         ST_SEND_BYTE: begin
            if (q_chg)  sda_oe_d = ~shreg_q[7];
            if (q_rise) scl_d = 1'b1;
            if (q_end) begin
               scl_d   = 1'b0;
               bit_d   = bit_q + 3'd1;
               shreg_d = {shreg_q[6:0], 1'b0};
               if (bit_q == 3'd7) state_d = ST_GET_ACK;
            end
         end
         ST_GET_ACK: begin
            if (q_chg)  sda_oe_d = 1'b0;
            if (q_rise) scl_d = 1'b1;
            if (q_smp && sda_in_i) err_d = 1'b1;
            if (q_end) begin
               scl_d = 1'b0;
               if (err_q) state_d = ST_STOP;
               else begin
                  case (step_q)
                     2'd0: begin
                        shreg_d = req_q.rg;
                        step_d  = 2'd1;
                        state_d = ST_SEND_BYTE;
                     end
                     2'd1: begin
                        step_d  = 2'd2;
                        shreg_d = req_q.wd;
                        state_d = req_q.rw ? ST_RESTART : ST_SEND_BYTE;
                     end
                     default: state_d = req_q.rw ? ST_READ_BYTE : ST_STOP;
                  endcase
               end
            end
         end
         // Release SDA while SCL low, raise SCL, then pull SDA low under it.
         ST_RESTART: begin
            if (q_chg)  sda_oe_d = 1'b0;
            if (q_rise) scl_d = 1'b1;
            if (q_smp)  sda_oe_d = 1'b1;
            if (q_end) begin
               scl_d   = 1'b0;
               shreg_d = {req_q.dev, 1'b1};
               state_d = ST_SEND_BYTE;
            end
         end
         ST_READ_BYTE: begin
            if (q_chg)  sda_oe_d = 1'b0;
            if (q_rise) scl_d = 1'b1;
            if (q_smp)  shreg_d = {shreg_q[6:0], sda_in_i};
            if (q_end) begin
               scl_d = 1'b0;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_SEND_NACK;
            end
         end
         ST_SEND_NACK: begin
            if (q_chg)  sda_oe_d = 1'b0;
            if (q_rise) scl_d = 1'b1;
            if (q_end) begin
               scl_d   = 1'b0;
               state_d = ST_STOP;
            end
         end
         // Status and read data are registered on the way into DONE so they
         // line up with the single DONE cycle.
         ST_STOP: begin
            if (q_chg)  sda_oe_d = 1'b1;
            if (q_rise) scl_d = 1'b1;
            if (q_smp)  sda_oe_d = 1'b0;
            if (q_end) begin
               sts_d    = err_q ? STS_NACK : STS_DONE;
               sts_wr_d = 1'b1;
               if (req_q.rw && !err_q) rd_data_d = shreg_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         ph_q      <= 2'd0;
         bit_q     <= 3'd0;
         step_q    <= 2'd0;
         shreg_q   <= 8'd0;
         err_q     <= 1'b0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
         sts_q     <= STS_IDLE;
         sts_wr_q  <= 1'b0;
         rd_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         step_q    <= step_d;
         shreg_q   <= shreg_d;
         err_q     <= err_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         sts_q     <= sts_d;
         sts_wr_q  <= sts_wr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data_o = rd_data_q;
   assign sts_o     = sts_q;
   assign sts_wr_o  = sts_wr_q;
   assign scl_o     = scl_q;
   assign sda_oe_o  = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a bus monitor and behavioural slave decode the wire
// into START/byte+ack/STOP events, compared with a transaction-level model.
module tb_i2c_master;

   localparam int unsigned DIV = 4;
   localparam int EV_S = 1000;
   localparam int EV_P = 2000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] dev = '0;
   logic [7:0] rg = '0;
   logic [7:0] wd = '0;
   logic [7:0] rd_data;
   logic [1:0] sts;
   logic       sts_wr, scl, sda_oe, sda_in;
   logic       slv_pull = 1'b0;

   assign sda_in = !sda_oe && !slv_pull;

   i2c_master #(.CLK_DIV(DIV)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .rw_i       (rw),
      .dev_addr_i (dev),
      .reg_addr_i (rg),
      .wr_data_i  (wd),
      .rd_data_o  (rd_data),
      .sts_o      (sts),
      .sts_wr_o   (sts_wr),
      .scl_o      (scl),
      .sda_oe_o   (sda_oe),
      .sda_in_i   (sda_in)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nbad = 0;
   int trace[$];
   int sts_log[$];
   int exp_q[$];
   int pulses = 0, per_bad = 0, per_n = 0;
   int mon_bitn = 0, mon_frame = 0;
   int cyc = 0, last_rise = -1;
   logic scl_p = 1'b1, sda_p = 1'b1, sda_b;
   logic in_tx = 1'b0, first_s = 1'b0, slv_tx = 1'b0, ackv = 1'b0;
   logic [7:0] shv = '0;
   logic [7:0] slv_rdata = '0;
   int slv_nf = -1;
   logic [7:0] mdl_rd = '0;

   // Monitor + slave: bits sampled on SCL rise, slave drives only after SCL falls.
   always @(negedge clk) begin
      cyc++;
      sda_b = !sda_oe && !slv_pull;
      if (rst) begin
         mon_bitn = 0; mon_frame = 0; in_tx = 0; first_s = 0; slv_tx = 0;
         slv_pull = 0; last_rise = -1; pulses = 0;
      end else begin
         if (sts_wr) begin
            pulses++;
            sts_log.push_back(int'(sts));
         end
         if (scl_p && scl && sda_p && !sda_b) begin
            trace.push_back(EV_S);
            if (!in_tx) begin mon_frame = 0; slv_tx = 0; end
            in_tx = 1; first_s = 1; mon_bitn = 0;
         end else if (scl_p && scl && !sda_p && sda_b) begin
            trace.push_back(EV_P);
            in_tx = 0; last_rise = -1; mon_bitn = 0;
         end
         if (!scl_p && scl) begin
            if (last_rise >= 0) begin
               per_n++;
               if (cyc - last_rise != int'(4 * DIV)) per_bad++;
            end
            last_rise = cyc;
            if (mon_bitn < 8) shv = {shv[6:0], sda_b};
            else ackv = sda_b;
            mon_bitn++;
            if (mon_bitn == 9) begin
               trace.push_back(int'(shv) + (ackv ? 256 : 0));
               slv_tx = first_s && shv[0] && !ackv;
               first_s = 0;
               mon_frame++;
            end
         end
         if (scl_p && !scl) begin
            if (mon_bitn == 9) mon_bitn = 0;
            slv_pull = 0;
            if (in_tx) begin
               if (slv_tx) begin
                  if (mon_bitn < 8) slv_pull = !slv_rdata[7 - mon_bitn];
               end else if (mon_bitn == 8) slv_pull = (mon_frame != slv_nf);
            end
         end
      end
      scl_p = scl;
      sda_p = sda_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ncmp++;
      assert (obs === expv) else begin
         nbad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Transaction-level model: list of master-sent bytes, first NACKed frame ends it.
   task automatic build_exp(input logic r, input logic [6:0] d, input logic [7:0] g,
                            input logic [7:0] w, input logic [7:0] sd, input int nf,
                            output int es);
      logic [7:0] b [3];
      logic nk;
      b[0] = {d, 1'b0};
      b[1] = g;
      b[2] = r ? {d, 1'b1} : w;
      exp_q.delete();
      exp_q.push_back(EV_S);
      es = 2;
      for (int i = 0; i < 3; i++) begin
         if (r && i == 2) exp_q.push_back(EV_S);
         nk = (i == nf);
         exp_q.push_back(int'(b[i]) + (nk ? 256 : 0));
         if (nk) begin
            exp_q.push_back(EV_P);
            es = 3;
            return;
         end
      end
      if (r) begin
         exp_q.push_back(int'(sd) + 256);
         mdl_rd = sd;
      end
      exp_q.push_back(EV_P);
   endtask

   task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] g,
                          input logic [7:0] w, input logic [7:0] sd, input int nf,
                          input logic dup);
      int es, nmis, s0, s1;
      logic got;
      slv_rdata = sd;
      slv_nf = nf;
      build_exp(r, d, g, w, sd, nf, es);
      @(negedge clk);
      trace.delete(); sts_log.delete();
      pulses = 0; per_bad = 0; per_n = 0;
      rw = r; dev = d; rg = g; wd = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("accept_sts", 32'(sts), 1);
      chk("accept_strobe", 32'(sts_wr), 1);
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge clk);
         if (dup && k == 40) begin
            start = 1'b1; rw = ~r; dev = ~d; rg = ~g; wd = ~w;
         end else start = 1'b0;
         if (sts_wr) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 32'(got), 1);
      chk("done_sts", 32'(sts), 32'(es));
      chk("done_rd_data", 32'(rd_data), 32'(mdl_rd));
      @(negedge clk);
      chk("idle_strobe", 32'(sts_wr), 0);
      chk("idle_scl", 32'(scl), 1);
      chk("idle_sda_oe", 32'(sda_oe), 0);
      repeat (3) @(negedge clk);
      chk("hold_sts", 32'(sts), 32'(es));
      chk("hold_rd_data", 32'(rd_data), 32'(mdl_rd));
      chk("strobe_count", 32'(pulses), 2);
      s0 = (sts_log.size() > 0) ? sts_log[0] : -1;
      s1 = (sts_log.size() > 1) ? sts_log[1] : -1;
      chk("strobe_sts0", 32'(s0), 1);
      chk("strobe_sts1", 32'(s1), 32'(es));
      nmis = 0;
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= trace.size() || trace[i] != exp_q[i]) nmis++;
      chk("trace_len", 32'(trace.size()), 32'(exp_q.size()));
      chk("trace_items_bad", 32'(nmis), 0);
      chk("scl_period_bad", 32'(per_bad), 0);
      chk("scl_periods_seen", 32'(per_n > 8), 1);
   endtask

   initial begin
      logic got;
      int nf;
      repeat (3) @(negedge clk);
      chk("rst_scl", 32'(scl), 1);
      chk("rst_sda_oe", 32'(sda_oe), 0);
      chk("rst_sts", 32'(sts), 0);
      chk("rst_strobe", 32'(sts_wr), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_txn(1'b0, 7'h1A, 8'h05, 8'hA5, 8'h00, -1, 1'b0);
      run_txn(1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, -1, 1'b0);
      run_txn(1'b0, 7'h22, 8'h05, 8'hA5, 8'h00, 0, 1'b0);
      run_txn(1'b0, 7'h1A, 8'h05, 8'hA5, 8'h00, -1, 1'b1);

      // Reset in the middle of the register byte, bit 3.
      slv_nf = -1;
      @(negedge clk);
      rw = 1'b0; dev = 7'h1A; rg = 8'h05; wd = 8'hA5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 3000 && !got; k++) begin
         @(negedge clk);
         if (mon_frame == 1 && mon_bitn == 3) got = 1'b1;
      end
      chk("midrst_reached", 32'(got), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_scl", 32'(scl), 1);
      chk("midrst_sda_oe", 32'(sda_oe), 0);
      chk("midrst_sts", 32'(sts), 0);
      chk("midrst_strobe", 32'(sts_wr), 0);
      chk("midrst_rd_data", 32'(rd_data), 0);
      @(negedge clk);
      rst = 1'b0;
      mdl_rd = '0;
      repeat (60) @(negedge clk);
      chk("midrst_no_strobe", 32'(pulses), 0);
      chk("midrst_bus_idle", 32'({scl, sda_oe}), 32'b10);
      run_txn(1'b0, 7'h1A, 8'h05, 8'hA5, 8'h00, -1, 1'b0);

      for (int t = 0; t < 12; t++) begin
         nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
         run_txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), nf, ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
